// File: rtl/trn_bclksclk_ml.sv
// trn_bclksclk_ml: multi-lane BCLK-to-SCLK alignment trainer.
// Rotates the shared VCO phase one step at a time, watches every enabled lane's
// gearbox RX pattern for a valid transition, then applies a programmable offset.
// Optional register readback port: define TRN_BCLKSCLK_RDDATA_EN to add
// apb_addr/bclk_rddata; without it those ports and their logic are absent.
module trn_bclksclk_ml #(
   parameter int unsigned NUM_LANES     = 2,
   parameter int unsigned GEAR_W        = 4,
   parameter int unsigned MAX_ROT       = 72,
   parameter int unsigned RESET_EVERY   = 9,
   parameter int unsigned CHECK_CYCLES  = 1024,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned RESET_WAIT    = 31,
   parameter int unsigned OFFSET_W      = 3
) (
   input  logic                          sclk,
   input  logic                          reset_b,
   input  logic                          train,
   input  logic [NUM_LANES*GEAR_W-1:0]   bclk_igear_rx,
   input  logic [NUM_LANES-1:0]          lane_en,
   input  logic [OFFSET_W-1:0]           vcophs_offset,
   output logic                          vcophsel_bclk_sel,
   output logic                          vcophsel_rotate,
   output logic                          loadphs_b,
   output logic                          cmd_reset_lane,
   output logic                          done,
   output logic                          train_err,
   output logic [NUM_LANES-1:0]          lane_seen,
`ifdef TRN_BCLKSCLK_RDDATA_EN
   input  logic [3:0]                    apb_addr,
   output logic [7:0]                    bclk_rddata,
`endif
   output logic [7:0]                    rot_count
);

   // One shared delay/window counter, sized for the longest wait it must hold.
   localparam int unsigned MaxA   = (RESET_WAIT > SETTLE_CYCLES) ? RESET_WAIT : SETTLE_CYCLES;
   localparam int unsigned CntMax = (MaxA > CHECK_CYCLES - 1) ? MaxA : CHECK_CYCLES - 1;
   localparam int unsigned CntW   = (CntMax > 0) ? $clog2(CntMax + 1) : 1;

   typedef enum logic [4:0] {
      StIdle = 5'd0, StRese, StResw, StLoad, StDem, StChk, StRot, StMrst,
      StMrsw, StRreg, StOfst, StOfs2, StPaus, StWait, StDone, StFail
   } state_e;

   state_e                        r_state;
   state_e                        w_state_nxt;
   logic                          r_train_q;
   logic [CntW-1:0]               r_cnt;
   logic [OFFSET_W-1:0]           r_ofs_cnt;
   logic [7:0]                    r_rot_count;
   logic [NUM_LANES-1:0]          r_lane_en;
   logic [NUM_LANES-1:0]          r_lane_seen;
   logic [NUM_LANES*GEAR_W-1:0]   r_prev;
   logic                          r_bsel;
   logic                          r_rotate;
   logic                          r_cmd_reset;
   logic                          r_done;
   logic                          r_err;

   logic                          w_train_rise;
   logic                          w_cnt_last;
   logic [NUM_LANES-1:0]          w_trans;
   logic [NUM_LANES-1:0]          w_seen_nxt;
   logic                          w_all_seen;
   logic [7:0]                    w_rot_inc;
   logic                          w_rst_due;

   assign w_train_rise = train & ~r_train_q;
   // Waits leave on the cycle the counter reaches zero, so a load of N lasts N cycles.
   assign w_cnt_last   = (r_cnt <= CntW'(1));
   assign w_rot_inc    = (r_rot_count == 8'hFF) ? 8'hFF : r_rot_count + 8'd1;
   assign w_rst_due    = ((w_rot_inc % 8'(RESET_EVERY)) == 8'd0);

   // Per-lane transition detect; zero on either side never counts.
   always_comb begin
      w_trans = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         w_trans[i] = (r_prev[i*GEAR_W +: GEAR_W] != bclk_igear_rx[i*GEAR_W +: GEAR_W]) &&
                      (bclk_igear_rx[i*GEAR_W +: GEAR_W] != '0) &&
                      (r_prev[i*GEAR_W +: GEAR_W] != '0);
      end
   end

   assign w_seen_nxt = r_lane_seen | (w_trans & r_lane_en);
   assign w_all_seen = ((w_seen_nxt & r_lane_en) == r_lane_en);

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (w_train_rise) w_state_nxt = StRese;
         StRese:  w_state_nxt = StResw;
         StResw:  if (w_cnt_last) w_state_nxt = StLoad;
         StLoad:  w_state_nxt = (lane_en == '0) ? StFail : StDem;
         StDem:   if (w_cnt_last) w_state_nxt = StChk;
         StChk: begin
            if (w_all_seen)                         w_state_nxt = StOfst;
            else if (r_cnt != '0)                   w_state_nxt = StChk;
            else if (r_rot_count == 8'(MAX_ROT))    w_state_nxt = StFail;
            else                                    w_state_nxt = StRot;
         end
         StRot:   w_state_nxt = w_rst_due ? StMrst : StDem;
         StMrst:  w_state_nxt = StMrsw;
         StMrsw:  if (w_cnt_last) w_state_nxt = StRreg;
         StRreg:  w_state_nxt = StDem;
         StOfst:  w_state_nxt = (r_ofs_cnt == vcophs_offset) ? StPaus : StOfs2;
         StOfs2:  w_state_nxt = StOfst;
         StPaus:  w_state_nxt = StWait;
         StWait:  if (w_cnt_last) w_state_nxt = StDone;
         StDone, StFail: if (w_train_rise) w_state_nxt = StRese;
         default: w_state_nxt = StIdle;
      endcase
   end

   // State, datapath and outputs; outputs are registered from the next state.
   always_ff @(posedge sclk or negedge reset_b) begin
      if (!reset_b) begin
         r_state     <= StIdle;
         r_train_q   <= 1'b0;
         r_cnt       <= '0;
         r_ofs_cnt   <= '0;
         r_rot_count <= '0;
         r_lane_en   <= '0;
         r_lane_seen <= '0;
         r_prev      <= '0;
         r_bsel      <= 1'b0;
         r_rotate    <= 1'b0;
         r_cmd_reset <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_train_q   <= train;
         r_bsel      <= !(w_state_nxt inside {StIdle, StDone, StFail});
         r_rotate    <= (w_state_nxt inside {StRot, StOfs2});
         r_cmd_reset <= (w_state_nxt inside {StRese, StMrst, StPaus});
         r_done      <= (w_state_nxt inside {StDone, StFail});
         r_err       <= (w_state_nxt == StFail);
         case (r_state)
            StRese, StMrst: r_cnt <= CntW'(RESET_WAIT);
            StResw, StMrsw, StWait: if (r_cnt != '0) r_cnt <= r_cnt - CntW'(1);
            StLoad: begin
               r_rot_count <= '0;
               r_lane_en   <= lane_en;
               r_prev      <= bclk_igear_rx;
               r_cnt       <= CntW'(SETTLE_CYCLES);
            end
            StDem: begin
               r_lane_seen <= '0;
               if (w_cnt_last) r_cnt <= CntW'(CHECK_CYCLES - 1);
               else            r_cnt <= r_cnt - CntW'(1);
            end
            StChk: begin
               r_prev      <= bclk_igear_rx;
               r_lane_seen <= w_seen_nxt;
               r_ofs_cnt   <= '0;
               if (r_cnt != '0) r_cnt <= r_cnt - CntW'(1);
            end
            StRot: begin
               r_rot_count <= w_rot_inc;
               r_cnt       <= CntW'(SETTLE_CYCLES);
            end
            StRreg: begin
               r_prev <= bclk_igear_rx;
               r_cnt  <= CntW'(SETTLE_CYCLES);
            end
            StOfs2: r_ofs_cnt <= r_ofs_cnt + OFFSET_W'(1);
            StPaus: r_cnt <= CntW'(SETTLE_CYCLES);
            default: ;
         endcase
      end
   end

   assign vcophsel_bclk_sel = r_bsel;
   assign vcophsel_rotate   = r_rotate;
   assign loadphs_b         = 1'b1;
   assign cmd_reset_lane    = r_cmd_reset;
   assign done              = r_done;
   assign train_err         = r_err;
   assign lane_seen         = r_lane_seen;
   assign rot_count         = r_rot_count;

`ifdef TRN_BCLKSCLK_RDDATA_EN
   localparam int unsigned SeenW = (NUM_LANES < 8) ? NUM_LANES : 8;

   logic [7:0] r_rddata;
   logic [7:0] w_seen8;

   assign w_seen8 = 8'(r_lane_seen[SeenW-1:0]);

   // Readback mux, registered one cycle after the address.
   always_ff @(posedge sclk or negedge reset_b) begin
      if (!reset_b) begin
         r_rddata <= '0;
      end else begin
         case (apb_addr)
            4'd0:    r_rddata <= r_rot_count;
            4'd1:    r_rddata <= {r_err, r_done, 1'b0, r_state};
            4'd2:    r_rddata <= w_seen8;
            default: r_rddata <= '0;
         endcase
      end
   end

   assign bclk_rddata = r_rddata;
`endif

endmodule
